// File: rtl/uart_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the byte-receiver state encoding and the frame data width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Serial line in, plus the memory-write and status bundle out of the loader.
// The master side is the loader itself; the slave side is whoever consumes it.
interface uart_loader_if #(
  parameter int ADDR_W = 8
);

  logic              rx;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       memdata;
  logic [31:0]       rx_check;
  logic [31:0]       rx_checkh;
  logic [31:0]       rx_checkl;

  modport master (
    input  rx,
    output rx_data, rx_valid, frame_err, we, addr,
    output memdata, rx_check, rx_checkh, rx_checkl
  );

  modport slave (
    output rx,
    input  rx_data, rx_valid, frame_err, we, addr,
    input  memdata, rx_check, rx_checkh, rx_checkl
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizer, baud/bit counters and the frame FSM.
// Emits one-cycle byte_valid / byte_err pulses on the stop-bit sample edge.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic                      prev_q, prev_d;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;

  // A start is only taken on a high-to-low transition, so a line stuck low
  // after a bad stop bit cannot re-trigger frames until it goes high again.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q && prev_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          err_d   = !sync2_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/uart_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words,
// writes them to instruction memory at an auto-incrementing address, keeps a checksum.
module uart_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_loader_if.master  bus
);

  localparam logic [1:0] LAST_LANE = 2'(32 / UART_DATA_BITS - 1);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (bus.rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       memdata_q, memdata_d;
  logic [63:0]       csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [31:0]       full_word;

  // Errored bytes never touch the lane index, so the next good byte lands
  // in the same lane; addr steps only once the write cycle has been seen.
  always_comb begin
    full_word = word_q;
    full_word[{idx_q, 3'b000} +: 8] = byte_data;
    idx_d       = idx_q;
    word_d      = word_q;
    memdata_d   = memdata_q;
    csum_d      = csum_q;
    we_d        = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = byte_valid;
    frame_err_d = byte_err;
    addr_d      = we_q ? addr_q + 1'b1 : addr_q;
    if (byte_valid) begin
      rx_data_d = byte_data;
      word_d    = full_word;
      idx_d     = idx_q + 1'b1;
      if (idx_q == LAST_LANE) begin
        memdata_d = full_word;
        we_d      = 1'b1;
        csum_d    = csum_q + {32'd0, full_word};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      word_q      <= '0;
      memdata_q   <= '0;
      csum_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      word_q      <= word_d;
      memdata_q   <= memdata_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.memdata   = memdata_q;
  assign bus.rx_check  = memdata_q;
  assign bus.rx_checkh = csum_q[63:32];
  assign bus.rx_checkl = csum_q[31:0];

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: drives 8N1 frames on rx and compares
// writes, address and checksum against a word-level reference model.
module tb_uart_loader;

  localparam int CPB = 4;
  localparam int AW  = 8;
  localparam int LOG = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_W(AW)) bus ();

  uart_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int rv_cnt = 0;
  int fe_cnt = 0;
  int we_cnt = 0;
  logic [AW-1:0] we_addr_log [LOG];
  logic [31:0]   we_data_log [LOG];
  logic [31:0]   we_chk_log  [LOG];
  logic [63:0]   we_csum_log [LOG];

  logic [63:0] ref_csum;

  // Pulse monitor; records every write with the status visible in that cycle.
  always @(negedge clk) begin
    if (bus.rx_valid)  rv_cnt <= rv_cnt + 1;
    if (bus.frame_err) fe_cnt <= fe_cnt + 1;
    if (bus.we && we_cnt < LOG) begin
      we_addr_log[we_cnt] <= bus.addr;
      we_data_log[we_cnt] <= bus.memdata;
      we_chk_log[we_cnt]  <= bus.rx_check;
      we_csum_log[we_cnt] <= {bus.rx_checkh, bus.rx_checkl};
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_bits);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
    repeat (gap_bits * CPB) @(negedge clk);
    ref_csum = ref_csum + {32'd0, w};
  endtask

  task automatic do_reset();
    bus.rx = 1'b1;
    reset  = 1'b0;
    wait_cycles(3);
    reset  = 1'b1;
    wait_cycles(3);
    ref_csum = '0;
  endtask

  task automatic test_reset();
    logic [8+1+1+1+AW+32*4-1:0] outs;
    bus.rx = 1'b1;
    reset  = 1'b0;
    wait_cycles(3);
    outs = {bus.rx_data, bus.rx_valid, bus.frame_err, bus.we, bus.addr,
            bus.memdata, bus.rx_check, bus.rx_checkh, bus.rx_checkl};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected all zero", outs);
    end
    reset = 1'b1;
    wait_cycles(3);
    ref_csum = '0;
  endtask

  task automatic test_single_word();
    int base_we, base_rv;
    do_reset();
    base_we = we_cnt;
    base_rv = rv_cnt;
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    wait_cycles(8);
    checks++;
    if (rv_cnt - base_rv !== 4) begin
      errors++; $display("[TB] FAIL single_rx_valid_count: got %0d, expected 4", rv_cnt - base_rv);
    end
    checks++;
    if (we_cnt - base_we !== 1) begin
      errors++; $display("[TB] FAIL single_we_count: got %0d, expected 1", we_cnt - base_we);
    end
    checks++;
    if (we_addr_log[base_we] !== 8'd0) begin
      errors++; $display("[TB] FAIL single_we_addr: got %0d, expected 0", we_addr_log[base_we]);
    end
    checks++;
    if (we_data_log[base_we] !== 32'h12345678 || we_chk_log[base_we] !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL single_word: memdata %h rx_check %h, expected 12345678",
               we_data_log[base_we], we_chk_log[base_we]);
    end
    checks++;
    if (we_csum_log[base_we] !== 64'h0000_0000_1234_5678) begin
      errors++; $display("[TB] FAIL single_csum: got %h, expected 0000000012345678", we_csum_log[base_we]);
    end
    checks++;
    if (bus.addr !== 8'd1 || bus.rx_data !== 8'h12) begin
      errors++; $display("[TB] FAIL single_after: addr %0d rx_data %h, expected 1 / 12", bus.addr, bus.rx_data);
    end
  endtask

  task automatic test_carry();
    int base_we;
    do_reset();
    base_we = we_cnt;
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0001, 0);
    wait_cycles(8);
    checks++;
    if (we_cnt - base_we !== 2 || we_addr_log[base_we] !== 8'd0 || we_addr_log[base_we+1] !== 8'd1) begin
      errors++;
      $display("[TB] FAIL carry_writes: count %0d addrs %0d %0d, expected 2 writes at 0 1",
               we_cnt - base_we, we_addr_log[base_we], we_addr_log[base_we+1]);
    end
    checks++;
    if (bus.rx_checkh !== 32'h1 || bus.rx_checkl !== 32'h0) begin
      errors++;
      $display("[TB] FAIL carry_csum: got %h_%h, expected 00000001_00000000", bus.rx_checkh, bus.rx_checkl);
    end
  endtask

  task automatic test_glitch();
    int base_rv, base_fe;
    logic [7:0] b;
    base_rv = rv_cnt;
    base_fe = fe_cnt;
    @(negedge clk);
    bus.rx = 1'b0;
    @(negedge clk);
    bus.rx = 1'b1;
    wait_cycles(20);
    checks++;
    if (rv_cnt !== base_rv || fe_cnt !== base_fe) begin
      errors++;
      $display("[TB] FAIL glitch_pulses: rx_valid %0d frame_err %0d, expected 0 0",
               rv_cnt - base_rv, fe_cnt - base_fe);
    end
    b = 8'($urandom);
    send_byte(b, 1'b1);
    wait_cycles(4);
    checks++;
    if (rv_cnt - base_rv !== 1 || bus.rx_data !== b) begin
      errors++;
      $display("[TB] FAIL glitch_recover: rx_valid %0d rx_data %h, expected 1 / %h",
               rv_cnt - base_rv, bus.rx_data, b);
    end
  endtask

  task automatic test_frame_err();
    int base_rv, base_fe, base_we;
    logic [31:0] w;
    do_reset();
    base_rv = rv_cnt;
    base_fe = fe_cnt;
    base_we = we_cnt;
    send_byte(8'hA5, 1'b0);
    bus.rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    bus.rx = 1'b1;
    wait_cycles(3 * CPB);
    checks++;
    if (fe_cnt - base_fe !== 1 || rv_cnt !== base_rv || we_cnt !== base_we) begin
      errors++;
      $display("[TB] FAIL ferr_pulses: frame_err %0d rx_valid %0d we %0d, expected 1 0 0",
               fe_cnt - base_fe, rv_cnt - base_rv, we_cnt - base_we);
    end
    w = {8'($urandom), 8'($urandom), 8'($urandom), 8'hA5};
    send_byte(8'hA5, 1'b1);
    wait_cycles(4);
    checks++;
    if (bus.rx_data !== 8'hA5 || rv_cnt - base_rv !== 1) begin
      errors++;
      $display("[TB] FAIL ferr_retry_byte: rx_data %h count %0d, expected A5 / 1", bus.rx_data, rv_cnt - base_rv);
    end
    for (int i = 1; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
    ref_csum = ref_csum + {32'd0, w};
    wait_cycles(8);
    checks++;
    if (we_cnt - base_we !== 1 || we_addr_log[base_we] !== 8'd0 || we_data_log[base_we] !== w
        || we_csum_log[base_we] !== ref_csum) begin
      errors++;
      $display("[TB] FAIL ferr_word: count %0d addr %0d data %h csum %h, expected 1 / 0 / %h / %h",
               we_cnt - base_we, we_addr_log[base_we], we_data_log[base_we], we_csum_log[base_we], w, ref_csum);
    end
  endtask

  task automatic test_back_to_back();
    int base_we;
    logic [31:0] words [6];
    logic [63:0] sums  [6];
    do_reset();
    base_we = we_cnt;
    for (int k = 0; k < 6; k++) begin
      words[k] = $urandom;
      send_word(words[k], $urandom_range(0, 2));
      sums[k] = ref_csum;
    end
    wait_cycles(8);
    checks++;
    if (we_cnt - base_we !== 6) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d, expected 6", we_cnt - base_we);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (we_addr_log[base_we+k] !== AW'(k) || we_data_log[base_we+k] !== words[k]
          || we_chk_log[base_we+k] !== words[k] || we_csum_log[base_we+k] !== sums[k]) begin
        errors++;
        $display("[TB] FAIL b2b_word%0d: addr %0d data %h chk %h csum %h, expected %0d / %h / %h",
                 k, we_addr_log[base_we+k], we_data_log[base_we+k], we_chk_log[base_we+k],
                 we_csum_log[base_we+k], k, words[k], sums[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int base_we;
    logic [31:0] w;
    do_reset();
    base_we = we_cnt;
    for (int k = 0; k < 255; k++) send_word($urandom, 0);
    wait_cycles(8);
    checks++;
    if (bus.addr !== 8'd255 || we_cnt - base_we !== 255) begin
      errors++;
      $display("[TB] FAIL wrap_preload: addr %0d writes %0d, expected 255 / 255", bus.addr, we_cnt - base_we);
    end
    w = $urandom;
    send_word(w, 0);
    wait_cycles(8);
    checks++;
    if (we_addr_log[base_we+255] !== 8'd255 || we_data_log[base_we+255] !== w
        || we_csum_log[base_we+255] !== ref_csum) begin
      errors++;
      $display("[TB] FAIL wrap_last_write: addr %0d data %h csum %h, expected 255 / %h / %h",
               we_addr_log[base_we+255], we_data_log[base_we+255], we_csum_log[base_we+255], w, ref_csum);
    end
    checks++;
    if (bus.addr !== 8'd0 || {bus.rx_checkh, bus.rx_checkl} !== ref_csum) begin
      errors++;
      $display("[TB] FAIL wrap_after: addr %0d csum %h, expected 0 / %h",
               bus.addr, {bus.rx_checkh, bus.rx_checkl}, ref_csum);
    end
  endtask

  task automatic test_reset_mid();
    int base_we;
    logic [7:0] b;
    logic [31:0] w;
    logic [8+1+1+1+AW+32*4-1:0] outs;
    do_reset();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom) | 8'h01, 1'b1);
    b = 8'($urandom);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    #3;
    reset = 1'b0;
    #1;
    outs = {bus.rx_data, bus.rx_valid, bus.frame_err, bus.we, bus.addr,
            bus.memdata, bus.rx_check, bus.rx_checkh, bus.rx_checkl};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h, expected all zero", outs);
    end
    bus.rx = 1'b1;
    wait_cycles(4);
    reset = 1'b1;
    ref_csum = '0;
    wait_cycles(3 * CPB);
    base_we = we_cnt;
    w = $urandom;
    send_word(w, 0);
    wait_cycles(8);
    checks++;
    if (we_cnt - base_we !== 1 || we_addr_log[base_we] !== 8'd0 || we_data_log[base_we] !== w
        || we_csum_log[base_we] !== ref_csum) begin
      errors++;
      $display("[TB] FAIL midreset_word: count %0d addr %0d data %h csum %h, expected 1 / 0 / %h / %h",
               we_cnt - base_we, we_addr_log[base_we], we_data_log[base_we], we_csum_log[base_we], w, ref_csum);
    end
  endtask

  initial begin
    bus.rx   = 1'b1;
    ref_csum = '0;
    test_reset();
    test_single_word();
    test_carry();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader sitting directly upstream of the CPU top level: it receives 8N1 UART bytes on a single RX line, assembles them little-endian into 32-bit instruction words, and writes each word into instruction memory at an auto-incrementing address. It also exposes the last received byte, the last assembled word, and a 64-bit running word checksum, so the simulation bench and board LEDs can confirm a download before the core is released from reset.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4. Benches use 4.
- `ADDR_W`, default 8: instruction-memory word-address width.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `rx`, input, 1: asynchronous serial line; idle high.
- `rx_data`, output, 8: last accepted byte.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` updates.
- `frame_err`, output, 1: one-cycle pulse when a stop bit samples low.
- `we`, output, 1: one-cycle instruction-memory write strobe.
- `addr`, output, ADDR_W: word address for the current or next write.
- `memdata`, output, 32: write data; holds the last assembled word.
- `rx_check`, output, 32: last assembled word (mirrors `memdata`).
- `rx_checkh`, output, 32: upper half of the 64-bit checksum.
- `rx_checkl`, output, 32: lower half of the 64-bit checksum.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Byte FSM:** states IDLE, START, DATA, STOP.
  - IDLE → START when the synchronized `rx` is 0.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 0 → DATA. If 1 → IDLE as a glitch, with no pulse.
  - DATA: sample every CLKS_PER_BIT cycles. Eight bits, LSB first, into the shift register. After bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: byte accepted, `rx_valid` pulses.
    - If 0: `frame_err` pulses, the byte is discarded and does not advance the byte index.
    - Either way, go to IDLE.
- **Word assembly:**
  - A 2-bit byte index selects the lane: byte 0 goes to bits [7:0], byte 3 to bits [31:24].
  - On acceptance of byte 3: `memdata` and `rx_check` take the full word, `we` pulses, and the 64-bit checksum becomes checksum + zero-extended word (mod 2^64). The index wraps to 0.
- **Addressing:** `addr` increments on the edge that ends the `we` cycle. It wraps from 2^ADDR_W−1 to 0.
- **Framing errors:** no error recovery inside a word. A framing error leaves the partial word intact, and the next good byte fills the same lane.

## Timing
- **Reset values:** every output is 0. Internal state: FSM IDLE, byte index 0, synchronizer 1.
- **Reset mid-frame:** returns to IDLE and discards the partial word and byte.
- **Latency:** `rx_valid`, `rx_data`, `we`, `memdata`, `rx_check` and the checksum all update on the same edge, one cycle after the stop-bit sample edge. The checksum value seen in that cycle already includes the new word.
- **During `we`:** `addr` holds the address of the current write.
- **Line hold:** a line held low after a frame error gives one START per falling edge seen in IDLE. No frame restarts until `rx` returns high.
- **Throughput:** back-to-back frames with no idle gap are supported. The FSM is in IDLE at least one cycle before the next start bit's centre.

## Structure
- **Package `uart_pkg`:** state enum `rx_state_t` (IDLE, START, DATA, STOP) and constant `UART_DATA_BITS = 8`.
- **Sub-module `uart_rx_byte`:** synchronizer, bit counter, baud counter and FSM. Outputs `byte_data` and the `byte_valid` / `byte_err` pulses.
- **`uart_loader`:** instantiates `uart_rx_byte` and adds word assembly, address counter and checksum.

## Test plan
Benches set CLKS_PER_BIT=4.
- Send 0x78, 0x56, 0x34, 0x12 → four `rx_valid` pulses; one `we` with `addr`=0, `memdata`=`rx_check`=0x12345678, checksum 0x0000_0000_1234_5678; `addr`=1 afterwards.
- Send words 0xFFFFFFFF then 0x00000001 → two `we` at `addr` 0 and 1; final `rx_checkh`=0x0000_0001, `rx_checkl`=0x0000_0000.
- Low glitch of 1 cycle on idle `rx` → no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Byte 0xA5 with stop bit 0 → one `frame_err` pulse, no `rx_valid`; then 0xA5 with a good stop bit → `rx_data`=0xA5 in lane 0.
- Preload `addr` to 255 by sending 255 words, then one more word → `we` at 255 and `addr` wraps to 0.
- Assert `reset` low mid-DATA of byte 2 → all outputs 0 immediately. The next four good bytes form a word written at `addr` 0.
